led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
- Sequences the 8-bit user LED bank from the board switches, replacing the direct switch-to-LED mirror in the processor top.
- Push switches are synchronised, debounced and edge-detected, and give start/pause, single-step, clear and invert commands.
- DIP switches select the pattern mode, direction and speed.
- Pattern steps advance on 1-cycle ticks from the existing pulse generator.

Parameters:
- pDebounceCycles, 500000, consecutive stable cycles before a push-switch level is accepted (10 ms at 50 MHz).
- pStepDiv, 4, ticks per pattern step in normal speed (>=1).

Ports:
- iSysClk  in  1  system clock (50 MHz).
- iSysRst  in  1  synchronous, active-high reset.
- iTick  in  1  single-cycle pulse from the pulse generator.
- iUserDipSw  in  4  raw DIP switches. [1:0] mode; [2] direction (0 = left/up); [3] fast (1 = step every tick).
- iUserPushSw  in  4  raw push switches, 1 = pressed. [0] start/pause; [1] step; [2] clear; [3] invert toggle.
- oUserLed  out  8  registered LED drive.
- oRun  out  1  high in RUN.
- oState  out  2  current state encoding.

Behaviour:
- Reset (synchronous, one edge):
  - State IDLE, pattern = seed of current mode, invert = 0, tick counter = 0, debounce stable levels = 0.
  - Outputs: oUserLed = 0x00, oRun = 0, oState = IDLE (0).
- Input conditioning:
  - All 8 switch inputs pass through a 2-FF synchroniser.
  - Push bits are then debounced: the stable level changes only after the synchronised input has differed from it for pDebounceCycles consecutive cycles.
  - A press pulse is generated for 1 cycle on a 0->1 transition of the stable level.
- States: IDLE = 0, RUN = 1, PAUSE = 2; encoding 3 is unused and recovers to IDLE.
  - IDLE + start -> RUN.
  - RUN + start -> PAUSE.
  - PAUSE + start -> RUN.
  - Any state + clear -> IDLE, pattern reloaded with seed, invert cleared.
  - Clear takes priority over start, step and invert presses in the same cycle.
- Step pulse rules:
  - Step press is honoured only in PAUSE: the pattern advances exactly one step.
  - Step press is ignored in IDLE and RUN.
  - Step and start in the same cycle in PAUSE: start wins and no step occurs.
- Tick divide:
  - The counter increments on iTick in RUN only; it is held at 0 otherwise.
  - Divisor = 1 if DIP[3] = 1, else pStepDiv.
  - When a tick arrives with counter = divisor-1, the pattern advances and the counter returns to 0.
  - A divisor change mid-count is safe: use a >= divisor-1 compare.
- Timing:
  - The pattern register updates on the edge after the qualifying tick or step pulse.
  - oUserLed updates on the following edge: 2 cycles of latency from iTick.
  - Debounce adds pDebounceCycles+3 cycles from a switch edge to its press pulse.
- Mode change:
  - A change in synchronised DIP[1:0] reloads the seed on the next edge.
  - State and tick counter are kept.
  - A mode change coincident with an advance: the reload wins.
- Patterns (8 bit). DIP[2] is read at each step unless stated otherwise.
  - Mode 0, walking one: seed 0x01. Rotate left (dir 0) or right (dir 1); 0x80 -> 0x01 wraps.
  - Mode 1, bounce:
    - Seed 0x01 with internal direction left, or 0x80 with direction right when DIP[2] = 1 at seed load.
    - Shift one position per step; at the end bit the internal direction reverses (0x80 -> 0x40, 0x01 -> 0x02).
    - DIP[2] is otherwise ignored.
  - Mode 2, counter: seed 0x00. +1 (dir 0) or -1 (dir 1) modulo 256; 0xFF -> 0x00 and 0x00 -> 0xFF.
  - Mode 3, LFSR:
    - Seed 0x01. Shift left, new bit0 = b7^b5^b4^b3.
    - Period 255; never reaches 0x00; direction ignored.
- Output: oUserLed = 0x00 in IDLE; otherwise pattern XOR {8{invert}}. An invert press toggles invert in RUN and PAUSE and is ignored in IDLE.

Decomposition:
- Package led_ctrl_pkg holds:
  - State enum (IDLE/RUN/PAUSE).
  - Mode enum (WALK/BOUNCE/COUNT/LFSR).
  - Seed constants and the LFSR tap mask.
  - Push-switch bit index constants.
- Sub-module sw_debounce: 1-bit, parameter pDebounceCycles; contains the sync FFs, counter, stable level and press pulse. Instantiated 4 times.
- DIP synchronisers stay in the top module.

Test Plan (pDebounceCycles = 4, pStepDiv = 2, iTick every 10 cycles):
- Reset, mode 0, press start (held 8 cycles) -> oState 0->1, oUserLed 0x01, then 0x02, 0x04 every 20 cycles; 0x80 -> 0x01 wrap.
- Mode 2, DIP[2] = 1, fast -> oUserLed 0x00, 0xFF, 0xFE on successive ticks, each 2 cycles after iTick.
- Mode 1 run to the end -> sequence ..0x40, 0x80, 0x40, 0x20.. and ..0x02, 0x01, 0x02.
- Mode 3 -> first steps 0x01, 0x02, 0x04, 0x08, 0x11; no 0x00 over 255 steps; step 255 returns 0x01.
- Press start (PAUSE), then step twice, then a 2-cycle glitch on step -> exactly 2 advances, glitch ignored. Invert press -> oUserLed = ~pattern.
- Clear and start pressed together in RUN -> IDLE, oUserLed 0x00, invert 0. Assert iSysRst mid-RUN -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED pattern sequencer: states, pattern
// modes, seeds, LFSR taps and push-switch bit positions.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_WALK   = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_LFSR   = 2'd3
    } mode_e;

    localparam logic [7:0] SEED_WALK     = 8'h01;
    localparam logic [7:0] SEED_BOUNCE_L = 8'h01;
    localparam logic [7:0] SEED_BOUNCE_R = 8'h80;
    localparam logic [7:0] SEED_COUNT    = 8'h00;
    localparam logic [7:0] SEED_LFSR     = 8'h01;

    // Feedback taps b7, b5, b4, b3: maximal-length, period 255.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int PB_START  = 0;
    localparam int PB_STEP   = 1;
    localparam int PB_CLEAR  = 2;
    localparam int PB_INVERT = 3;

    function automatic logic [7:0] f_seed(input logic [1:0] mode, input logic dir);
        logic [7:0] seed;
        case (mode)
            MODE_WALK:   seed = SEED_WALK;
            MODE_BOUNCE: seed = dir ? SEED_BOUNCE_R : SEED_BOUNCE_L;
            MODE_COUNT:  seed = SEED_COUNT;
            MODE_LFSR:   seed = SEED_LFSR;
        endcase
        return seed;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One push-switch channel: 2-FF synchroniser, stability counter, accepted
// level and a single-cycle press strobe on its 0->1 transition.
module sw_debounce #(
    parameter int pDebounceCycles = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_press
);

    localparam int CW = $clog2(pDebounceCycles + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(pDebounceCycles - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= i_sw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
            // Any cycle agreeing with the accepted level restarts the count.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/led_pattern_ctrl.sv
// User LED sequencer: debounced push commands drive an IDLE/RUN/PAUSE FSM that
// steps one of four 8-bit patterns selected by the DIP switches.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int pDebounceCycles = 500000,
    parameter int pStepDiv        = 4
) (
    input  logic       iSysClk,
    input  logic       iSysRst,
    input  logic       iTick,
    input  logic [3:0] iUserDipSw,
    input  logic [3:0] iUserPushSw,
    output logic [7:0] oUserLed,
    output logic       oRun,
    output logic [1:0] oState
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_PAUSE = ST_PAUSE;

    localparam int CNT_W = (pStepDiv > 1) ? $clog2(pStepDiv + 1) : 1;
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(pStepDiv - 1);

    logic [3:0]       r_dip_s1;
    logic [3:0]       r_dip_s2;
    logic [1:0]       r_mode;
    logic [1:0]       r_state;
    logic [7:0]       r_pattern;
    logic [7:0]       r_led;
    logic             r_invert;
    logic             r_bdir;
    logic [CNT_W-1:0] r_tick_cnt;

    logic [3:0]       w_press;
    logic [1:0]       w_mode;
    logic             w_dir;
    logic             w_fast;
    logic             w_mode_chg;
    logic             w_start;
    logic             w_step;
    logic             w_clear;
    logic             w_invert;
    logic             w_active;
    logic [CNT_W-1:0] w_div_last;
    logic             w_tick_adv;
    logic             w_step_adv;
    logic             w_advance;
    logic [7:0]       w_next_pat;
    logic             w_next_bdir;

    // Push commands are single-cycle strobes with no backpressure: a strobe is
    // acted on in the cycle it is high or not at all.
    for (genvar g = 0; g < 4; g++) begin : g_push
        sw_debounce #(
            .pDebounceCycles(pDebounceCycles)
        ) u_db (
            .i_clk  (iSysClk),
            .i_rst  (iSysRst),
            .i_sw   (iUserPushSw[g]),
            .o_press(w_press[g])
        );
    end

    always_ff @(posedge iSysClk) begin
        r_dip_s1 <= iUserDipSw;
        r_dip_s2 <= r_dip_s1;
    end

    assign w_mode     = r_dip_s2[1:0];
    assign w_dir      = r_dip_s2[2];
    assign w_fast     = r_dip_s2[3];
    assign w_mode_chg = (w_mode != r_mode);

    assign w_start  = w_press[PB_START];
    assign w_step   = w_press[PB_STEP];
    assign w_clear  = w_press[PB_CLEAR];
    assign w_invert = w_press[PB_INVERT];
    assign w_active = (r_state == S_RUN) || (r_state == S_PAUSE);

    assign w_div_last = w_fast ? '0 : SLOW_LAST;
    assign w_tick_adv = (r_state == S_RUN) && iTick && (r_tick_cnt >= w_div_last);
    assign w_step_adv = (r_state == S_PAUSE) && w_step && !w_start;
    assign w_advance  = w_tick_adv || w_step_adv;

    always_comb begin
        w_next_pat  = r_pattern;
        w_next_bdir = r_bdir;
        case (w_mode)
            MODE_WALK: begin
                w_next_pat = w_dir ? {r_pattern[0], r_pattern[7:1]}
                                   : {r_pattern[6:0], r_pattern[7]};
            end
            MODE_BOUNCE: begin
                // r_bdir: 0 = moving towards bit 7, 1 = towards bit 0.
                if (!r_bdir) begin
                    if (r_pattern[7]) begin
                        w_next_pat  = r_pattern >> 1;
                        w_next_bdir = 1'b1;
                    end else begin
                        w_next_pat = r_pattern << 1;
                    end
                end else begin
                    if (r_pattern[0]) begin
                        w_next_pat  = r_pattern << 1;
                        w_next_bdir = 1'b0;
                    end else begin
                        w_next_pat = r_pattern >> 1;
                    end
                end
            end
            MODE_COUNT: begin
                w_next_pat = w_dir ? (r_pattern - 8'd1) : (r_pattern + 8'd1);
            end
            MODE_LFSR: begin
                w_next_pat = {r_pattern[6:0], ^(r_pattern & LFSR_TAPS)};
            end
        endcase
    end

    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            r_state    <= S_IDLE;
            r_pattern  <= f_seed(w_mode, w_dir);
            r_bdir     <= w_dir;
            r_mode     <= w_mode;
            r_invert   <= 1'b0;
            r_tick_cnt <= '0;
            r_led      <= 8'h00;
        end else begin
            r_mode <= w_mode;
            r_led  <= w_active ? (r_pattern ^ {8{r_invert}}) : 8'h00;

            if (w_clear) begin
                r_state   <= S_IDLE;
                r_pattern <= f_seed(w_mode, w_dir);
                r_bdir    <= w_dir;
                r_invert  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE:  if (w_start) r_state <= S_RUN;
                    S_RUN:   if (w_start) r_state <= S_PAUSE;
                    S_PAUSE: if (w_start) r_state <= S_RUN;
                    default: r_state <= S_IDLE;
                endcase

                if (w_invert && w_active) begin
                    r_invert <= ~r_invert;
                end

                // A mode change overrides any advance in the same cycle.
                if (w_mode_chg) begin
                    r_pattern <= f_seed(w_mode, w_dir);
                    r_bdir    <= w_dir;
                end else if (w_advance) begin
                    r_pattern <= w_next_pat;
                    r_bdir    <= w_next_bdir;
                end
            end

            if (w_clear || (r_state != S_RUN)) begin
                r_tick_cnt <= '0;
            end else if (iTick) begin
                r_tick_cnt <= (r_tick_cnt >= w_div_last) ? '0 : (r_tick_cnt + 1'b1);
            end
        end
    end

    assign oUserLed = r_led;
    assign oRun     = (r_state == S_RUN);
    assign oState   = r_state;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed plus randomized bench for led_pattern_ctrl, checked against a
// behavioural model of the LED sequencer kept in this file.
module tb_led_pattern_ctrl;

    localparam int DEB = 4;
    localparam int DIV = 2;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;

    localparam logic [3:0] B_START  = 4'b0001;
    localparam logic [3:0] B_STEP   = 4'b0010;
    localparam logic [3:0] B_CLEAR  = 4'b0100;
    localparam logic [3:0] B_INVERT = 4'b1000;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] dip  = 4'h0;
    logic [3:0] push = 4'h0;
    logic [7:0] led;
    logic       run;
    logic [1:0] st;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model of the sequencer.
    int         m_state;
    logic [7:0] m_pat;
    bit         m_inv;
    bit         m_bdir;
    int         m_cnt;

    logic [7:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    led_pattern_ctrl #(
        .pDebounceCycles(DEB),
        .pStepDiv       (DIV)
    ) dut (
        .iSysClk    (clk),
        .iSysRst    (rst),
        .iTick      (tick),
        .iUserDipSw (dip),
        .iUserPushSw(push),
        .oUserLed   (led),
        .oRun       (run),
        .oState     (st)
    );

    // ---------------- model ----------------
    function automatic logic [7:0] m_seed();
        case (dip[1:0])
            2'd0:    return 8'h01;
            2'd1:    return dip[2] ? 8'h80 : 8'h01;
            2'd2:    return 8'h00;
            default: return 8'h01;
        endcase
    endfunction

    function automatic void m_reload();
        m_pat  = m_seed();
        m_bdir = dip[2];
    endfunction

    function automatic int onehot_pos(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic void m_advance();
        int pos;
        case (dip[1:0])
            2'd0: begin
                pos   = onehot_pos(m_pat);
                pos   = dip[2] ? (pos + 7) % 8 : (pos + 1) % 8;
                m_pat = 8'(1 << pos);
            end
            2'd1: begin
                pos = onehot_pos(m_pat);
                if (!m_bdir) begin
                    if (pos == 7) begin m_bdir = 1'b1; pos = 6; end
                    else pos = pos + 1;
                end else begin
                    if (pos == 0) begin m_bdir = 1'b0; pos = 1; end
                    else pos = pos - 1;
                end
                m_pat = 8'(1 << pos);
            end
            2'd2: m_pat = 8'((int'(m_pat) + (dip[2] ? 255 : 1)) % 256);
            default: m_pat = {m_pat[6:0], 1'($countones(m_pat & 8'hB8) % 2)};
        endcase
    endfunction

    function automatic logic [7:0] exp_led();
        return (m_state == S_IDLE) ? 8'h00 : (m_pat ^ {8{m_inv}});
    endfunction

    function automatic void m_press(input logic [3:0] mask);
        int old;
        if (mask[2]) begin
            m_state = S_IDLE;
            m_reload();
            m_inv = 1'b0;
            m_cnt = 0;
        end else begin
            old = m_state;
            if (mask[0]) m_state = (old == S_RUN) ? S_PAUSE : S_RUN;
            if (mask[1] && !mask[0] && old == S_PAUSE) m_advance();
            if (mask[3] && old != S_IDLE) m_inv = !m_inv;
            if (m_state != S_RUN) m_cnt = 0;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_led"}, led, exp_led());
        chk({tag, "_run"}, {7'd0, run}, (m_state == S_RUN) ? 8'd1 : 8'd0);
        chk({tag, "_state"}, {6'd0, st}, 8'(m_state));
    endtask

    // ---------------- drivers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick(input string tag);
        logic [7:0] e_old;
        int div;
        e_old = exp_led();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk({tag, "_lat1"}, led, e_old);
        if (m_state == S_RUN) begin
            div = dip[3] ? 1 : DIV;
            if (m_cnt >= div - 1) begin
                m_advance();
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(negedge clk);
        chk({tag, "_lat2"}, led, exp_led());
        cyc(7);
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge clk);
        push = mask;
        cyc(hold);
        push = 4'h0;
        cyc(12);
        if (hold >= DEB) m_press(mask);
        check_outputs("press");
    endtask

    task automatic set_dip(input logic [3:0] v);
        logic chg;
        chg = (v[1:0] != dip[1:0]);
        @(negedge clk);
        dip = v;
        if (chg) m_reload();
        cyc(6);
        check_outputs("dip");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_zero;
        int r;

        cyc(5);
        rst = 1'b0;
        m_state = S_IDLE;
        m_reload();
        m_inv = 1'b0;
        m_cnt = 0;
        cyc(2);
        check_outputs("reset");
        chk("reset_led_const", led, 8'h00);

        // Walking one, slow: one advance per two ticks, wraps 0x80 -> 0x01.
        press(B_START, 8);
        chk("start_state", {6'd0, st}, 8'd1);
        chk("start_led", led, 8'h01);
        exp_q = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        while (exp_q.size() > 0) begin
            do_tick("walk");
            do_tick("walk");
            chk("walk_seq", led, exp_q.pop_front());
        end

        // Counter, down, fast.
        set_dip(4'b1110);
        chk("count_seed", led, 8'h00);
        exp_q = '{8'hFF, 8'hFE};
        while (exp_q.size() > 0) begin
            do_tick("count");
            chk("count_seq", led, exp_q.pop_front());
        end

        // Bounce, fast, starting left.
        set_dip(4'b1001);
        chk("bounce_seed", led, 8'h01);
        exp_q = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        while (exp_q.size() > 0) begin
            do_tick("bounce");
            chk("bounce_seq", led, exp_q.pop_front());
        end

        // LFSR, fast: full period.
        set_dip(4'b1011);
        chk("lfsr_seed", led, 8'h01);
        exp_q = '{8'h02, 8'h04, 8'h08, 8'h11};
        n_zero = 0;
        for (int i = 0; i < 255; i++) begin
            do_tick("lfsr");
            if (led === 8'h00) n_zero++;
            if (exp_q.size() > 0) chk("lfsr_first", led, exp_q.pop_front());
        end
        chk("lfsr_nozero", 8'(n_zero), 8'h00);
        chk("lfsr_period", led, 8'h01);

        // Pause, single steps, glitch rejection, invert.
        set_dip(4'b0000);
        press(B_START, 8);
        chk("pause_state", {6'd0, st}, 8'd2);
        chk("pause_led", led, 8'h01);
        press(B_STEP, 8);
        chk("step1", led, 8'h02);
        press(B_STEP, 8);
        chk("step2", led, 8'h04);
        press(B_STEP, 2);
        chk("step_glitch", led, 8'h04);
        do_tick("pause_tick");
        press(B_INVERT, 8);
        chk("invert", led, 8'hFB);

        // Clear beats start; invert ignored in IDLE.
        press(B_START, 8);
        press(B_CLEAR | B_START, 8);
        chk("clear_state", {6'd0, st}, 8'd0);
        chk("clear_led", led, 8'h00);
        press(B_INVERT, 8);
        press(B_START, 8);
        chk("restart_led", led, 8'h01);

        // Randomized phase.
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 11);
            if (r <= 4)       do_tick("rnd_tick");
            else if (r == 5)  set_dip(4'($urandom_range(0, 15)));
            else if (r == 6)  press(B_START, 8);
            else if (r == 7)  press(B_STEP, 8);
            else if (r == 8)  press(B_INVERT, 8);
            else if (r == 9)  press(4'($urandom_range(1, 15)), 8);
            else if (r == 10) press(4'(1 << $urandom_range(0, 3)), 2);
            else if ($urandom_range(0, 3) == 0) press(B_CLEAR, 8);
            else do_tick("rnd_tick");
        end

        // Reset in the middle of RUN.
        if (m_state != S_RUN) press(B_START, 8);
        do_tick("pre_rst");
        do_tick("pre_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_led", led, 8'h00);
        chk("rst_run", {7'd0, run}, 8'd0);
        chk("rst_state", {6'd0, st}, 8'd0);
        rst = 1'b0;
        m_state = S_IDLE;
        m_reload();
        m_inv = 1'b0;
        m_cnt = 0;
        cyc(3);
        check_outputs("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
